// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: one-cycle multiplies and divide special cases,
// radix-2 restoring divider for general divides, valid/ready on both sides.
module muldiv_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  kill,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2:0]            funct3,
   input  logic [DATA_WIDTH-1:0] opranda,
   input  logic [DATA_WIDTH-1:0] oprandb,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] res
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(W) + 1;
   localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

   typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

   state_t          state, state_next;
   logic            accept;
   logic [2:0]      op;
   logic [W-1:0]    a_reg, b_reg, quo, rem, dvs;
   logic [CW-1:0]   cnt;

   // Request-side decode, evaluated on the unregistered inputs at accept
   logic            sgn_in, div_zero_in, ovf_in;
   logic [W-1:0]    mag_a_in, mag_b_in;

   assign accept      = in_valid && in_ready;
   assign sgn_in      = !funct3[0];
   assign div_zero_in = (oprandb == '0);
   assign ovf_in      = sgn_in && (opranda == {1'b1, {(W-1){1'b0}}}) && (&oprandb);
   assign mag_a_in    = (sgn_in && opranda[W-1]) ? -opranda : opranda;
   assign mag_b_in    = (sgn_in && oprandb[W-1]) ? -oprandb : oprandb;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      state_next = state;
      case (state)
         S_IDLE: if (accept) state_next = (!funct3[2] || div_zero_in || ovf_in) ? S_MUL : S_DIV;
         S_MUL:  state_next = S_DONE;
         S_DIV:  if (cnt == LAST_ITER) state_next = S_FIX;
         S_FIX:  state_next = S_DONE;
         S_DONE: if (out_ready) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
      if (kill) state_next = S_IDLE;
   end

   always_comb begin
      in_ready  = (state == S_IDLE) && !rst && !kill;
      out_valid = (state == S_DONE) && !rst && !kill;
   end

   // Multiply: sign-extend to 2W so one signed product covers all four variants
   logic          sa, sb;
   logic [2*W-1:0] ma, mb, prod;
   logic [W-1:0]  mul_res, sp_res, one_res, fix_res;
   logic [W:0]    sub;
   logic          ge;

   always_comb begin
      sa      = (op[1:0] != 2'b11);
      sb      = (op[1:0] == 2'b01);
      ma      = {{W{sa & a_reg[W-1]}}, a_reg};
      mb      = {{W{sb & b_reg[W-1]}}, b_reg};
      prod    = ma * mb;
      mul_res = (op[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
      if (b_reg == '0) sp_res = op[1] ? a_reg : '1;
      else             sp_res = op[1] ? '0    : a_reg;
      one_res = op[2] ? sp_res : mul_res;
      sub     = {rem, quo[W-1]} - {1'b0, dvs};
      ge      = !sub[W];
      fix_res = op[1] ? ((!op[0] && a_reg[W-1]) ? -rem : rem)
                      : ((!op[0] && (a_reg[W-1] ^ b_reg[W-1])) ? -quo : quo);
   end

   // NOTE: operand and divider registers carry no reset; they are always loaded on accept before being read.
   always_ff @(posedge clk) begin
      if (accept) begin
         op    <= funct3;
         a_reg <= opranda;
         b_reg <= oprandb;
         quo   <= mag_a_in;
         dvs   <= mag_b_in;
         rem   <= '0;
      end else if (state == S_DIV) begin
         quo <= {quo[W-2:0], ge};
         rem <= ge ? sub[W-1:0] : {rem[W-2:0], quo[W-1]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         res <= '0;
      end else begin
         if (accept)              cnt <= '0;
         else if (state == S_DIV) cnt <= cnt + 1'b1;
         if (state == S_MUL)      res <= one_res;
         else if (state == S_FIX) res <= fix_res;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected results, a
// negedge monitor pops and compares value and latency on each handshake.
module tb_muldiv_unit;

   logic        clk = 0, rst = 1, kill = 0, in_valid = 0, out_ready = 1;
   logic        in_ready, out_valid;
   logic [2:0]  funct3 = 0;
   logic [31:0] opranda = 0, oprandb = 0, res;

   muldiv_unit #(.DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .kill(kill), .in_valid(in_valid), .in_ready(in_ready),
      .funct3(funct3), .opranda(opranda), .oprandb(oprandb),
      .out_valid(out_valid), .out_ready(out_ready), .res(res)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      int          lat;
      int          acc;
      string       name;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_cmp = 0, n_bad = 0, cyc = 0, first = 0;
   bit   seen = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst || kill) seen = 0;
      else if (out_valid) begin
         if (!seen) begin
            seen  = 1;
            first = cyc;
         end
         if (out_ready) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_result: got %h expected none", res);
            end else begin
               e = sb.pop_front();
               check(e.name, res, e.res);
               check({e.name, " latency"}, 32'(first - e.acc), 32'(e.lat));
            end
            seen = 0;
         end
      end
   end

   task automatic issue(string nm, logic [2:0] f, logic [31:0] a, logic [31:0] b,
                        logic [31:0] exp, int lat, bit push);
      int t = 0;
      @(negedge clk);
      while (!in_ready && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) check({nm, " in_ready timeout"}, 32'd0, 32'd1);
      funct3   = f;
      opranda  = a;
      oprandb  = b;
      in_valid = 1;
      if (push) sb.push_back('{exp, lat, cyc, nm});
      @(posedge clk);
      #1;
      in_valid = 0;
      opranda  = 32'hDEAD_BEEF;
      oprandb  = 32'h0000_1234;
      funct3   = 3'($urandom);
   endtask

   task automatic drain();
      int t = 0;
      while (sb.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (sb.size() != 0) check("drain timeout", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      bit bad_valid;
      int t;
      repeat (2) @(negedge clk);
      check("reset in_ready", 32'(in_ready), 32'd0);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset res", res, 32'd0);
      @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      check("in_ready after reset", 32'(in_ready), 32'd1);

      issue("MUL 7*-3",       3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 2,  1);
      issue("MULHU max*max",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 2,  1);
      issue("MULH min*min",   3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 2,  1);
      issue("MULHSU -1*max",  3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 2,  1);
      issue("DIV -20/3",      3'b100, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, 34, 1);
      issue("REM -20/3",      3'b110, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, 34, 1);
      issue("DIVU 100/7",     3'b101, 32'd100,        32'd7,         32'd14,        34, 1);
      issue("REMU 100/7",     3'b111, 32'd100,        32'd7,         32'd2,         34, 1);
      issue("DIV 20/-3",      3'b100, 32'd20,         32'hFFFF_FFFD, 32'hFFFF_FFFA, 34, 1);
      issue("REM 20/-3",      3'b110, 32'd20,         32'hFFFF_FFFD, 32'd2,         34, 1);
      issue("DIV min/2",      3'b100, 32'h8000_0000,  32'd2,         32'hC000_0000, 34, 1);
      issue("REMU max/16",    3'b111, 32'hFFFF_FFFF,  32'd16,        32'd15,        34, 1);
      issue("DIVU 5/0",       3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 2,  1);
      issue("REM 5/0",        3'b110, 32'd5,          32'd0,         32'd5,         2,  1);
      issue("DIV min/-1",     3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2,  1);
      issue("REM min/-1",     3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         2,  1);
      drain();

      // Back-pressure: result held while out_ready is low
      out_ready = 0;
      issue("MUL 6*7 held", 3'b000, 32'd6, 32'd7, 32'd42, 2, 1);
      t = 0;
      while (!out_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      for (int i = 0; i < 5; i++) begin
         check("hold out_valid", 32'(out_valid), 32'd1);
         check("hold res", res, 32'd42);
         check("hold in_ready", 32'(in_ready), 32'd0);
         @(negedge clk);
      end
      @(posedge clk);
      #1 out_ready = 1;
      @(negedge clk);
      @(negedge clk);
      check("in_ready after handshake", 32'(in_ready), 32'd1);
      issue("MULHU after hold", 3'b011, 32'h0001_0000, 32'h0003_0000, 32'd3, 2, 1);
      drain();

      // kill in DIV iteration 10 discards the operation
      issue("DIVU killed", 3'b101, 32'd100, 32'd7, 32'd0, 0, 0);
      repeat (9) @(posedge clk);
      #1 kill = 1;
      @(posedge clk);
      #1 kill = 0;
      @(negedge clk);
      check("in_ready after kill", 32'(in_ready), 32'd1);
      bad_valid = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) bad_valid = 1;
      end
      check("no result after kill", 32'(bad_valid), 32'd0);

      // kill together with in_valid in IDLE: not accepted
      @(negedge clk);
      funct3 = 3'b000; opranda = 32'd2; oprandb = 32'd2;
      in_valid = 1; kill = 1;
      #1 check("in_ready under kill", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1 in_valid = 0; kill = 0;
      bad_valid = 0;
      repeat (5) begin
         @(negedge clk);
         if (out_valid) bad_valid = 1;
      end
      check("no accept under kill", 32'(bad_valid), 32'd0);

      // rst in the middle of a divide
      issue("DIV reset", 3'b100, 32'd1000, 32'd9, 32'd0, 0, 0);
      repeat (5) @(posedge clk);
      #1 rst = 1;
      @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      check("mid-div rst out_valid", 32'(out_valid), 32'd0);
      check("mid-div rst res", res, 32'd0);
      check("mid-div rst in_ready", 32'(in_ready), 32'd1);
      issue("MUL 3*4", 3'b000, 32'd3, 32'd4, 32'd12, 2, 1);
      drain();

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle multiply/divide unit implementing the RV32M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) next to the integer ALU in the execute stage. Accepts one operation at a time over a valid/ready handshake. Multiplies and divide special cases complete in fixed short latency; general divides run an iterative radix-2 restoring divider. A kill input aborts the operation in flight on pipeline flush.

## Interface

- DATA_WIDTH, 32, operand/result width; even, >= 8

- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- kill  input  1  synchronous abort of accepted/in-flight operation
- in_valid  input  1  request valid
- in_ready  output  1  unit can accept a request
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- opranda  input  DATA_WIDTH  operand a (rs1)
- oprandb  input  DATA_WIDTH  operand b (rs2)
- out_valid  output  1  result valid
- out_ready  input  1  consumer takes result
- res  output  DATA_WIDTH  result

## Operation

- States: IDLE, MUL, DIV, FIX, DONE.
- in_ready = (state == IDLE) && !rst && !kill. Accept = in_valid && in_ready; funct3 and operands registered on accept; later input changes ignored.
- IDLE -> MUL for funct3[2]=0; -> DONE-via-special-case for divide by zero or signed overflow; otherwise -> DIV.
- MUL: one cycle; full 2*DATA_WIDTH product of registered operands, sign-extended per op (MULH both signed, MULHSU a signed/b unsigned, MULHU both unsigned). MUL returns low half, others high half. -> DONE.
- Divide by zero (b == 0): quotient = all ones, remainder = a (DIV/DIVU/REM/REMU). Signed overflow (DIV/REM, a = most negative, b = -1): quotient = a, remainder = 0. Both resolved in one cycle (in MUL-equivalent slot), -> DONE.
- DIV: operate on magnitudes (abs for signed ops, raw for unsigned); DATA_WIDTH iterations, one quotient bit per cycle, counter width clog2(DATA_WIDTH)+1. -> FIX.
- FIX: signed ops: quotient negated if sign(a) != sign(b); remainder takes sign of a (truncate toward zero). Select quotient or remainder. -> DONE.
- DONE: out_valid = 1, res stable until out_valid && out_ready, then -> IDLE.
- Single outstanding operation; no accept while busy or in DONE.
- kill: any state -> IDLE next cycle, out_valid = 0, no result produced; in-flight state discarded. rst has priority over kill; kill over all else.

## Timing

- Reset: state IDLE, out_valid 0, res 0, counter 0, in_ready 0 during reset cycle, 1 in first cycle after rst deasserts.
- Accept in cycle 0. MUL/MULH*/special-case divide: out_valid in cycle 2. General divide: DIV cycles 1..DATA_WIDTH, FIX cycle DATA_WIDTH+1, out_valid in cycle DATA_WIDTH+2 (34 at default).
- out_ready may be high before out_valid; result consumed in the first cycle both high. in_ready returns in the following cycle; minimum initiation interval = latency + 1.
- res holds last value after handshake until next result is written; res is don't-care to consumers when out_valid = 0, except reset value 0.
- kill in same cycle as in_valid in IDLE: request not accepted. kill in DONE with out_ready high: result discarded (no handshake counted).

## Test plan

- MUL 7 * 0xFFFFFFFD -> res 0xFFFFFFEB, out_valid exactly 2 cycles after accept; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFEC/3 -> 0xFFFFFFFA, REM -> 0xFFFFFFFE, DIVU 100/7 -> 14, REMU -> 2; out_valid 34 cycles after accept.
- DIVU 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; all latency 2.
- out_ready low 5 cycles after out_valid -> out_valid and res held, in_ready 0; raise out_ready -> in_ready 1 next cycle, next op accepted.
- kill in DIV iteration 10 -> IDLE next cycle, no out_valid; rst mid-DIV -> all outputs reset values; subsequent MUL 3*4 -> 12 correct.
